// File: rtl/uart_tx_fifo_fsm_pkg.sv
// Shared definitions for the UART RX/TX FIFO sequencers: state set and
// default datapath widths.
package uart_tx_fifo_fsm_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_LOAD      = 3'd3,
    ST_WAIT_TX   = 3'd4,
    ST_GAP       = 3'd5
  } fifo_fsm_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_fsm_timeout_cnt.sv
// Loadable down-counter with clear; shared by the inter-byte gap and the
// transmit-done timeout.
module uart_tx_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_fifo_fsm.sv
// Drains the TX FIFO into the UART transmitter one byte at a time, with
// optional inter-byte gap and a sticky timeout on a missing tx_done.
module uart_tx_fifo_fsm
  import uart_tx_fifo_fsm_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int RD_LATENCY     = 1,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd_en,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_tx_dv,
  output logic [DATA_W-1:0] o_tx_byte,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_byte_count,
  output logic              o_timeout_err,
  input  logic              i_err_clr
);

  localparam int TMR_MAX = max_int(TIMEOUT_CYCLES, GAP_CYCLES);
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [1:0]       LAT_LAST = 2'(RD_LATENCY - 1);

  fifo_fsm_state_e   state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic              tx_dv_q, tx_dv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rd_en, busy;
  logic              tmr_clr, tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]  tmr_load_val;

  uart_tx_timeout_cnt #(
    .W (TMR_W)
  ) u_tmr (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    tx_byte_d    = tx_byte_q;
    tx_dv_d      = 1'b0;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rd_en        = 1'b0;
    busy         = 1'b0;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = '0;
    if (i_err_clr) err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (i_enable && !i_fifo_empty && !i_tx_active && !err_q) state_d = ST_READ;
      end
      ST_READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        lat_d   = '0;
        state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        busy = 1'b1;
        if (lat_q == LAT_LAST) state_d = ST_LOAD;
        else                   lat_d   = lat_q + 2'd1;
      end
      ST_LOAD: begin
        busy         = 1'b1;
        tx_byte_d    = i_fifo_data;
        tx_dv_d      = 1'b1;
        tmr_load     = 1'b1;
        tmr_load_val = TMO_LOAD;
        state_d      = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        busy = 1'b1;
        // A done coincident with the dv pulse belongs to a previous frame.
        if (i_tx_done && !tx_dv_q) begin
          cnt_d = cnt_q + 1'b1;
          if (GAP_CYCLES > 0) begin
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LOAD;
            state_d      = ST_GAP;
          end else begin
            tmr_clr = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (tmr_zero) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (tmr_zero) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      tx_byte_q <= tx_byte_d;
      tx_dv_q   <= tx_dv_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign o_fifo_rd_en  = rd_en;
  assign o_busy        = busy;
  assign o_tx_dv       = tx_dv_q;
  assign o_tx_byte     = tx_byte_q;
  assign o_byte_count  = cnt_q;
  assign o_timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_fifo_fsm.sv
// Randomised bench for uart_tx_fifo_fsm: FIFO and UART environment models
// plus a timeline-based reference for the expected outputs.
module tb_uart_tx_fifo_fsm;

  localparam int DW = 8;
  localparam int L  = 2;
  localparam int G  = 4;
  localparam int T  = 50;
  localparam int CW = 16;
  localparam longint INF = 64'sd1 << 40;

  logic          i_clk, i_rst_n, i_enable, i_fifo_empty, i_tx_active, i_tx_done, i_err_clr;
  logic [DW-1:0] i_fifo_data;
  logic          o_fifo_rd_en, o_tx_dv, o_busy, o_timeout_err;
  logic [DW-1:0] o_tx_byte;
  logic [CW-1:0] o_byte_count;

  uart_tx_fifo_fsm #(
    .DATA_W         (DW),
    .RD_LATENCY     (L),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T),
    .CNT_W          (CW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_enable      (i_enable),
    .i_fifo_empty  (i_fifo_empty),
    .o_fifo_rd_en  (o_fifo_rd_en),
    .i_fifo_data   (i_fifo_data),
    .o_tx_dv       (o_tx_dv),
    .o_tx_byte     (o_tx_byte),
    .i_tx_active   (i_tx_active),
    .i_tx_done     (i_tx_done),
    .o_busy        (o_busy),
    .o_byte_count  (o_byte_count),
    .o_timeout_err (o_timeout_err),
    .i_err_clr     (i_err_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  longint cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Environment state and knobs
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] pend_data = '0;
  longint pend_at = -1;
  int  uart_left = 0;
  bit  k_en = 0, k_silent = 0, k_spur = 0, k_clr_once = 0, k_rst_n = 0;
  int  k_push_pct = 0, k_clr_pct = 0;
  int  n_rd = 0, n_dv = 0;
  bit  last_rd = 0, last_dv = 0;

  // Reference: a byte transaction is described by its READ cycle and the
  // first idle cycle after it completes (INF while still in flight).
  longint        m_trd = -100, m_tend = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [DW-1:0] m_byte = '0, m_pend = '0;
  bit            m_err = 0;

  task automatic model_reset();
    m_trd = -100; m_tend = 0; m_cnt = '0; m_err = 0; m_byte = '0;
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    ref_q.push_back(b);
  endtask

  task automatic step();
    longint dv_c, last_c;
    bit set_err;
    @(negedge i_clk);
    cyc++;
    check("rd_en",    o_fifo_rd_en,  cyc == m_trd);
    check("tx_dv",    o_tx_dv,       cyc == m_trd + L + 2);
    check("busy",     o_busy,        (cyc >= m_trd) && (cyc < m_tend));
    check("tx_byte",  o_tx_byte,     m_byte);
    check("count",    o_byte_count,  m_cnt);
    check("tmo_err",  o_timeout_err, m_err);
    if (o_fifo_rd_en) n_rd++;
    if (o_tx_dv) n_dv++;
    last_rd = o_fifo_rd_en;
    last_dv = o_tx_dv;

    i_tx_done = 1'b0;
    if (o_fifo_rd_en) begin
      check("pop_nonempty", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) pend_data = fifo_q.pop_front();
      pend_at     = cyc + L;
      i_fifo_data = DW'($urandom);
    end else if (cyc == pend_at) begin
      i_fifo_data = pend_data;
    end
    if (uart_left > 0) begin
      uart_left--;
      if (uart_left == 0) begin
        i_tx_done   = 1'b1;
        i_tx_active = 1'b0;
      end
    end
    if (o_tx_dv && !k_silent) begin
      uart_left   = $urandom_range(3, 12);
      i_tx_active = 1'b1;
    end
    if (k_spur && $urandom_range(0, 29) == 0) i_tx_done = 1'b1;
    i_enable   = k_en;
    i_err_clr  = k_clr_once || ($urandom_range(0, 99) < k_clr_pct);
    k_clr_once = 0;
    if (fifo_q.size() < 16 && $urandom_range(0, 99) < k_push_pct) push_byte(DW'($urandom));
    i_fifo_empty = (fifo_q.size() == 0);
    i_rst_n      = k_rst_n;

    if (!i_rst_n) begin
      model_reset();
    end else begin
      set_err = 0;
      if (m_tend != INF) begin
        if (cyc >= m_tend && i_enable && !i_fifo_empty && !i_tx_active && !m_err
            && ref_q.size() > 0) begin
          m_trd  = cyc + 1;
          m_tend = INF;
          m_pend = ref_q.pop_front();
        end
      end else begin
        dv_c   = m_trd + L + 2;
        last_c = dv_c + T - 1;
        if (cyc > dv_c && cyc <= last_c && i_tx_done) begin
          m_cnt++;
          m_tend = cyc + 1 + G;
        end else if (cyc == last_c) begin
          set_err = 1;
          m_tend  = cyc + 1;
        end
      end
      if (set_err) m_err = 1;
      else if (i_err_clr) m_err = 0;
      if (cyc + 1 == m_trd + L + 2) m_byte = m_pend;
    end
  endtask

  task automatic wait_seen(input string tag, input bit want_dv, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = want_dv ? last_dv : last_rd;
    end
    check(tag, seen, 1);
  endtask

  int rd_mark;

  initial begin
    i_rst_n = 1'b0; i_enable = 1'b0; i_fifo_empty = 1'b1; i_fifo_data = '0;
    i_tx_active = 1'b0; i_tx_done = 1'b0; i_err_clr = 1'b0;

    repeat (3) step();
    check("rst_busy",  o_busy, 0);
    check("rst_count", o_byte_count, 0);
    k_rst_n = 1;

    // Empty FIFO with enable: nothing may happen.
    k_en = 1;
    repeat (100) step();
    check("empty_no_rd", n_rd, 0);
    check("empty_no_dv", n_dv, 0);

    push_byte(8'hA5);
    repeat (40) step();
    check("a5_count", o_byte_count, 1);
    check("a5_byte",  o_tx_byte, 8'hA5);
    check("a5_idle",  o_busy, 0);

    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    repeat (100) step();
    check("seq_count", o_byte_count, 4);
    check("seq_rd",    n_rd, 4);
    check("seq_dv",    n_dv, 4);

    // Transmitter never reports done: timeout, then blocked until cleared.
    k_silent = 1;
    push_byte(8'h5C); push_byte(8'h77);
    repeat (T + 20) step();
    check("tmo_set", o_timeout_err, 1);
    rd_mark = n_rd;
    repeat (60) step();
    check("tmo_no_pop", n_rd - rd_mark, 0);
    check("tmo_fifo",   fifo_q.size(), 1);
    k_silent   = 0;
    k_clr_once = 1;
    repeat (40) step();
    check("tmo_clr",    o_timeout_err, 0);
    check("tmo_resume", o_byte_count, 5);

    // Enable dropped while a byte is in flight.
    push_byte(8'h3C); push_byte(8'h4D);
    wait_seen("wait_dv_en", 1, 30);
    k_en = 0;
    rd_mark = n_rd;
    repeat (60) step();
    check("en_drop_count", o_byte_count, 6);
    check("en_drop_no_rd", n_rd - rd_mark, 0);
    k_en = 1;
    repeat (40) step();
    check("en_back_count", o_byte_count, 7);
    check("en_back_byte",  o_tx_byte, 8'h4D);

    // Asynchronous reset in the middle of WAIT_DATA.
    push_byte(8'h11); push_byte(8'h22);
    wait_seen("wait_rd_rst", 0, 30);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    k_rst_n = 0;
    #1;
    check("arst_rd",    o_fifo_rd_en, 0);
    check("arst_dv",    o_tx_dv, 0);
    check("arst_busy",  o_busy, 0);
    check("arst_byte",  o_tx_byte, 0);
    check("arst_count", o_byte_count, 0);
    check("arst_err",   o_timeout_err, 0);
    model_reset();
    uart_left = 0;
    i_tx_active = 1'b0;
    repeat (2) step();
    k_rst_n = 1;
    repeat (40) step();
    check("post_rst_count", o_byte_count, 1);
    check("post_rst_byte",  o_tx_byte, 8'h22);

    // Random traffic.
    k_spur = 1; k_push_pct = 20; k_clr_pct = 3;
    for (int blk = 0; blk < 30; blk++) begin
      k_en     = ($urandom_range(0, 3) != 0);
      k_silent = ($urandom_range(0, 7) == 0);
      repeat (100) step();
    end
    k_spur = 0; k_silent = 0; k_en = 1; k_push_pct = 0; k_clr_pct = 0;
    repeat (100) step();
    k_clr_once = 1;
    repeat (500) step();
    check("drain_fifo", fifo_q.size(), 0);
    check("drain_idle", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
